// File: rtl/bcd_para_binario_if.sv
// ============================================================================
// bcd_para_binario_if : start/data/result bundle of the BCD-to-binary converter
// Rev 1.0
// ============================================================================
`default_nettype none

interface bcd_para_binario_if #(
  parameter int DIGITOS = 2,
  parameter int BITS    = 7
);
  logic                   inicio;
  logic [4*DIGITOS-1:0]   bcd_in;
  logic [BITS-1:0]        binario;
  logic                   pronto;
  logic                   ocupado;
  logic                   erro;

  modport master (
    output inicio, bcd_in,
    input  binario, pronto, ocupado, erro
  );

  modport slave (
    input  inicio, bcd_in,
    output binario, pronto, ocupado, erro
  );
endinterface

`default_nettype wire

// File: rtl/bcd_para_binario.sv
// ============================================================================
// bcd_para_binario : sequential BCD-to-binary converter, reverse double-dabble
// Rev 1.0
// ============================================================================
`default_nettype none

module bcd_para_binario #(
  parameter int DIGITOS = 2,
  parameter int BITS    = 7
) (
  input  wire logic          clk,
  input  wire logic          rst,
  bcd_para_binario_if.slave  bus
);

  localparam int BCD_W = 4 * DIGITOS;
  localparam int CNT_W = $clog2(BITS + 1);

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    CONVERTE = 2'd1,
    FIM      = 2'd2
  } state_t;

  state_t              r_state;
  logic [BCD_W-1:0]    r_bcd;
  logic [BITS-1:0]     r_bin;
  logic [CNT_W-1:0]    r_cnt;
  logic [BITS-1:0]     r_binario;
  logic                r_pronto;
  logic                r_ocupado;
  logic                r_erro;

  logic [BCD_W+BITS-1:0] w_shifted;
  logic [BCD_W-1:0]      w_bcd_corr;
  logic [DIGITOS-1:0]    w_digit_bad;
  logic                  w_any_bad;

  assign w_shifted = {r_bcd, r_bin} >> 1;

  // Correction is applied after the shift: any digit that reached 8 or more
  // had a bit worth 10 moved into it, which must be worth 5 in binary.
  for (genvar i = 0; i < DIGITOS; i++) begin : g_digit
    logic [3:0] w_dig;
    assign w_dig = w_shifted[BITS+4*i +: 4];
    assign w_bcd_corr[4*i +: 4] = (w_dig >= 4'd8) ? (w_dig - 4'd3) : w_dig;
    assign w_digit_bad[i]       = (bus.bcd_in[4*i +: 4] > 4'd9);
  end

  assign w_any_bad = |w_digit_bad;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= OCIOSO;
      r_bcd     <= '0;
      r_bin     <= '0;
      r_cnt     <= '0;
      r_binario <= '0;
      r_pronto  <= 1'b0;
      r_ocupado <= 1'b0;
      r_erro    <= 1'b0;
    end else begin
      r_pronto <= 1'b0;
      case (r_state)
        OCIOSO: begin
          if (bus.inicio) begin
            r_bcd     <= bus.bcd_in;
            r_bin     <= '0;
            r_cnt     <= CNT_W'(BITS);
            r_ocupado <= 1'b1;
            if (w_any_bad) begin
              r_erro    <= 1'b1;
              r_binario <= '0;
              r_state   <= FIM;
            end else begin
              r_erro    <= 1'b0;
              r_state   <= CONVERTE;
            end
          end
        end
        CONVERTE: begin
          r_bcd <= w_bcd_corr;
          r_bin <= w_shifted[BITS-1:0];
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CNT_W'(1)) begin
            r_state <= FIM;
          end
        end
        FIM: begin
          r_binario <= r_erro ? '0 : r_bin;
          r_pronto  <= 1'b1;
          r_ocupado <= 1'b0;
          r_state   <= OCIOSO;
        end
        default: begin
          r_state <= OCIOSO;
        end
      endcase
    end
  end

  assign bus.binario = r_binario;
  assign bus.pronto  = r_pronto;
  assign bus.ocupado = r_ocupado;
  assign bus.erro    = r_erro;

endmodule

`default_nettype wire

// File: tb/tb_bcd_para_binario.sv
// ============================================================================
// tb_bcd_para_binario : directed self-checking bench for bcd_para_binario
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_bcd_para_binario;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  bcd_para_binario_if #(.DIGITOS(2), .BITS(7)) bus ();

  bcd_para_binario #(.DIGITOS(2), .BITS(7)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One request: start pulse, wait for pronto, check latency/result/busy/pulse width.
  task automatic run_conv(input logic [7:0] bcd, input int exp_bin, input logic exp_err,
                          input int exp_lat, input string tag);
    int lat;
    int busy;
    logic [6:0] bin_at_pronto;
    lat  = -1;
    busy = 0;
    bus.bcd_in = bcd;
    bus.inicio = 1'b1;
    @(posedge clk); #1;
    bus.inicio = 1'b0;
    if (bus.ocupado === 1'b1) busy++;
    for (int k = 1; k <= 20 && lat < 0; k++) begin
      @(posedge clk); #1;
      if (bus.pronto === 1'b1) lat = k;
      else if (bus.ocupado === 1'b1) busy++;
    end
    bin_at_pronto = bus.binario;
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_binario"}, 32'(bin_at_pronto), exp_bin);
    chk({tag, "_erro"}, 32'(bus.erro), 32'(exp_err));
    chk({tag, "_ocupado_cycles"}, busy, exp_lat);
    chk({tag, "_ocupado_at_pronto"}, 32'(bus.ocupado), 0);
    @(posedge clk); #1;
    chk({tag, "_pronto_single"}, 32'(bus.pronto), 0);
  endtask

  initial begin
    int n_pronto;
    int k_pronto;
    int k_second;
    checks     = 0;
    failures   = 0;
    rst        = 1'b1;
    bus.inicio = 1'b0;
    bus.bcd_in = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_binario", 32'(bus.binario), 0);
    chk("reset_pronto",  32'(bus.pronto),  0);
    chk("reset_ocupado", 32'(bus.ocupado), 0);
    chk("reset_erro",    32'(bus.erro),    0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_conv(8'h42, 42, 1'b0, 8, "c42");
    run_conv(8'h00,  0, 1'b0, 8, "c00");
    run_conv(8'h99, 99, 1'b0, 8, "c99");
    run_conv(8'h31, 31, 1'b0, 8, "c31");
    run_conv(8'h10, 10, 1'b0, 8, "c10");

    run_conv(8'h1A,  0, 1'b1, 1, "bad1A");
    run_conv(8'h07,  7, 1'b0, 8, "c07_after_bad");
    run_conv(8'hA3,  0, 1'b1, 1, "badA3");

    // Start 0x25, then stray starts with 0x88 land in CONVERTE and FIM.
    n_pronto = 0;
    k_pronto = -1;
    bus.bcd_in = 8'h25;
    bus.inicio = 1'b1;
    @(posedge clk); #1;
    bus.inicio = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      @(posedge clk); #1;
      if (bus.pronto === 1'b1) begin
        n_pronto++;
        k_pronto = k;
        chk("busy_binario", 32'(bus.binario), 25);
      end
      if (k >= 9) chk($sformatf("busy_no_restart_k%0d", k), 32'(bus.ocupado), 0);
      bus.inicio = (k == 2 || k == 7);
      bus.bcd_in = (k == 2 || k == 7) ? 8'h88 : 8'h25;
    end
    chk("busy_pronto_count", n_pronto, 1);
    chk("busy_pronto_latency", k_pronto, 8);

    // inicio held high: the second request follows FIM immediately.
    k_pronto = -1;
    k_second = -1;
    bus.bcd_in = 8'h12;
    bus.inicio = 1'b1;
    @(posedge clk); #1;
    for (int k = 1; k <= 24 && k_second < 0; k++) begin
      @(posedge clk); #1;
      if (bus.pronto === 1'b1) begin
        if (k_pronto < 0) begin
          k_pronto = k;
          chk("held_first_binario", 32'(bus.binario), 12);
          bus.bcd_in = 8'h34;
        end else begin
          k_second = k;
          chk("held_second_binario", 32'(bus.binario), 34);
        end
      end
      if (k == 9) begin
        chk("held_restart_ocupado", 32'(bus.ocupado), 1);
        bus.inicio = 1'b0;
      end
    end
    chk("held_first_latency", k_pronto, 8);
    chk("held_second_latency", k_second, 17);
    @(posedge clk); #1;

    // Reset in the middle of a conversion.
    bus.bcd_in = 8'h55;
    bus.inicio = 1'b1;
    @(posedge clk); #1;
    bus.inicio = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_binario", 32'(bus.binario), 0);
    chk("midrst_pronto",  32'(bus.pronto),  0);
    chk("midrst_ocupado", 32'(bus.ocupado), 0);
    chk("midrst_erro",    32'(bus.erro),    0);
    n_pronto = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (bus.pronto === 1'b1) n_pronto++;
    end
    chk("midrst_no_pronto", n_pronto, 0);
    run_conv(8'h63, 63, 1'b0, 8, "c63_after_rst");

    for (int t = 0; t < 10; t++) begin
      for (int u = 0; u < 10; u++) begin
        logic [3:0] tt;
        logic [3:0] uu;
        tt = 4'(t);
        uu = 4'(u);
        run_conv({tt, uu}, t * 10 + u, 1'b0, 8, $sformatf("sweep_%0d%0d", t, u));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/bcd_para_binario.md
# bcd_para_binario

Sequential BCD-to-binary converter: the inverse of the binary-to-decimal path feeding the seven-segment decoders. It accepts a packed BCD value (default two digits, tens and units from the board switches) and returns its binary equivalent by reverse double-dabble: one shift-and-correct step per clock. It sits between decimal operand entry and the binary adders. Valid/done is signalled with a one-cycle `pronto` pulse.

## Interface
- `DIGITOS`, default 2: number of BCD digits in `bcd_in`.
- `BITS`, default 7: width of `binario`. Legal only if 10^DIGITOS − 1 < 2^BITS; iteration count equals `BITS`.

- `clk`  in  1  single system clock; all state on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `inicio`  in  1  start request; sampled only in OCIOSO.
- `bcd_in`  in  4*DIGITOS  packed BCD, digit 0 (units) in bits [3:0].
- `binario`  out  BITS  converted value; held stable from `pronto` until the next accepted start.
- `pronto`  out  1  one-cycle done pulse.
- `ocupado`  out  1  high while a request is in progress (CONVERTE or FIM).
- `erro`  out  1  invalid input flag; a digit > 9 was present in the last accepted request.

## Operation
- States: OCIOSO, CONVERTE, FIM.
- OCIOSO: `ocupado`=0. On `inicio`=1:
  - Latch `bcd_in` into the BCD shift register, clear the binary shift register, load step counter = BITS.
  - If any digit > 9: `erro` ← 1, `binario` ← 0, go to FIM directly.
  - Otherwise `erro` ← 0, go to CONVERTE.
- CONVERTE, each cycle:
  - Shift concatenation {bcd_reg, bin_reg} right by 1; the LSB of digit 0 enters the MSB of bin_reg.
  - Then, in the same cycle, for every digit of the shifted BCD: if digit ≥ 8, subtract 3.
  - Decrement the counter. After the BITS-th step, go to FIM.
- FIM: `binario` ← bin_reg (or 0 on error), `pronto`=1 for this cycle only, then return to OCIOSO.
- `inicio` in CONVERTE or FIM is ignored: no queuing and no restart.
- `inicio` held high continuously: a new request is accepted each time OCIOSO is re-entered.
- Arithmetic:
  - Digit correction is 4-bit, unsigned, non-wrapping, since a digit ≥ 8 minus 3 is never negative.
  - The BCD register is zero after BITS steps for valid input. This is not checked.
- Reset (any cycle, including mid-conversion):
  - State → OCIOSO.
  - `binario`=0, `pronto`=0, `ocupado`=0, `erro`=0.
  - Internal registers cleared.
  - The in-flight request is discarded with no `pronto`.

## Timing
- `inicio` sampled high at edge N (valid input):
  - CONVERTE occupies edges N+1 … N+BITS.
  - `pronto`=1 and `binario` updated during the cycle after edge N+BITS+1; total latency BITS+1 cycles (8 by default).
- Invalid input: `pronto` and `erro` asserted after edge N+1; latency 1 cycle.
- `ocupado` rises after edge N and falls together with `pronto`.
- Minimum spacing between accepted requests: BITS+2 cycles for valid input, 2 for invalid input.
- `erro` is held until the next accepted start.

## Test plan
- Reset, then `bcd_in`=8'h42 with a one-cycle `inicio`:
  - `pronto` exactly 8 cycles later.
  - `binario`=7'd42, `erro`=0.
  - `ocupado` high for 8 cycles.
- Boundary values, back-to-back:
  - 8'h00 → 0.
  - 8'h99 → 7'd99.
  - 8'h31 → 31 (the adder's maximum sum).
  - 8'h10 → 10.
- Invalid input:
  - 8'h1A → `erro`=1, `binario`=0, `pronto` 1 cycle after start.
  - Follow with 8'h07 → `erro`=0, `binario`=7.
- Busy handling:
  - Start 8'h25, pulse `inicio` with 8'h88 at cycles 3 and 8 → single `pronto`, `binario`=25.
  - Held `inicio` → next conversion starts immediately after FIM.
- Reset at cycle 4 of a conversion:
  - All outputs 0 the next cycle and no `pronto` appears.
  - A new start of 8'h63 → 63.
- Exhaustive sweep: all 100 valid two-digit inputs against a scoreboard (tens*10+units); every `pronto` single-cycle, latency 8.
